// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
//   Shared types and constants for the pipeline sequencing controller.
//   - pctrl_state_t : controller FSM state (RUN / MWAIT / HALT)
//   - regbits_t     : 5-bit architectural register index
//   - RTYPE         : opcode carried by an all-zero bubble in any latch
package pipeline_ctrl_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    HALT  = 2'd2
  } pctrl_state_t;

  // A cleared latch reads as an R-type instruction with all-zero fields,
  // which the datapath treats as a no-op (sll $0,$0,0).
  localparam logic [5:0] RTYPE = 6'b000000;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect
//   Combinational load-use compare. A load sitting in ID/EX whose
//   destination matches a source of the instruction in IF/ID cannot have
//   its result forwarded in time, so one bubble is needed.
//   Inputs : ex_memread, ex_rd (ID/EX load), id_rs, id_rt (IF/ID sources)
//   Output : lu_hazard
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic     ex_memread,
  input  regbits_t ex_rd,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  output logic     lu_hazard
);

  // $zero is never a real dependency.
  assign lu_hazard = ex_memread && (ex_rd != '0) &&
                     ((ex_rd == id_rs) || (ex_rd == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Sequencing controller for the five-stage MIPS core. Each cycle it
//   decides between halt, freeze, branch flush, load-use bubble and normal
//   advance, drives the latch/PC strobes accordingly, issues each D-cache
//   request exactly once and keeps cycle/stall counters.
//   Inputs : CLK, RST (async, active high), ihit, dhit, mem_ren_i,
//            mem_wen_i, ex_memread, ex_rd, id_rs, id_rt, br_taken, wb_halt
//   Outputs: pc_en, {ifid,idex,exmem,memwb}_en, {ifid,idex,exmem,memwb}_clr,
//            dmem_ren, dmem_wen, halt, cyc_cnt, stall_cnt
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
)
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_ren_i,
  input  logic             mem_wen_i,
  input  logic             ex_memread,
  input  regbits_t         ex_rd,
  input  regbits_t         id_rs,
  input  regbits_t         id_rt,
  input  logic             br_taken,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_clr,
  output logic             idex_clr,
  output logic             exmem_clr,
  output logic             memwb_clr,
  output logic             dmem_ren,
  output logic             dmem_wen,
  output logic             halt,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  pctrl_state_t     state_q, state_d;
  logic             dgot_q, dgot_d;
  logic             igot_q, igot_d;
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lu_hazard;
  logic mem_op, mem_ready, if_ready, in_halt, hold, advance;
  logic lu_bubble, freeze;

  hazard_detect u_hazard_detect (
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .lu_hazard  (lu_hazard)
  );

  // dgot/igot remember a hit that arrived while the other side still
  // stalled, so the access is neither lost nor re-issued.
  assign mem_op    = mem_ren_i | mem_wen_i;
  assign mem_ready = ~mem_op | dhit | dgot_q;
  assign if_ready  = ihit | igot_q;
  assign in_halt   = (state_q == HALT);
  assign hold      = wb_halt | in_halt;
  assign advance   = mem_ready & if_ready & ~hold;
  // A taken branch squashes the dependent instruction anyway, so the
  // bubble is only real when no flush happens.
  assign lu_bubble = advance & ~br_taken & lu_hazard;
  assign freeze    = ~hold & ~advance;

  // Strobe decision. Forced low during reset because the state register
  // alone cannot mask combinational paths from ihit/dhit.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    pc_en     = 1'b0;
    ifid_en   = 1'b0;
    idex_en   = 1'b0;
    exmem_en  = 1'b0;
    memwb_en  = 1'b0;
    ifid_clr  = 1'b0;
    idex_clr  = 1'b0;
    exmem_clr = 1'b0;
    memwb_clr = 1'b0;
    dmem_ren  = 1'b0;
    dmem_wen  = 1'b0;
    if (!RST) begin
      if (advance) begin
        pc_en     = ~lu_bubble;
        ifid_en   = ~lu_bubble;
        idex_en   = 1'b1;
        exmem_en  = 1'b1;
        memwb_en  = 1'b1;
        ifid_clr  = br_taken;
        idex_clr  = br_taken | lu_bubble;
        exmem_clr = br_taken;
      end
      // A halt retiring in WB suppresses the younger memory access.
      dmem_ren = mem_ren_i & ~dgot_q & ~hold;
      dmem_wen = mem_wen_i & ~dgot_q & ~hold;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (wb_halt)                        state_d = HALT;
        else if (mem_op && !dhit && !dgot_q) state_d = MWAIT;
      end
      MWAIT: begin
        if (wb_halt)   state_d = HALT;
        else if (dhit) state_d = RUN;
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    dgot_d = dgot_q;
    if (advance)   dgot_d = 1'b0;
    else if (dhit) dgot_d = 1'b1;

    // During a load-use bubble the PC is held, so a fetch that completes
    // now is still the instruction IF/ID will load next cycle.
    igot_d = igot_q;
    if (lu_bubble)    igot_d = igot_q | ihit;
    else if (advance) igot_d = 1'b0;
    else if (ihit)    igot_d = 1'b1;

    cyc_cnt_d   = in_halt ? cyc_cnt_q : cyc_cnt_q + CNT_W'(1);
    stall_cnt_d = (freeze | lu_bubble) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= RUN;
      dgot_q      <= 1'b0;
      igot_q      <= 1'b0;
      cyc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      dgot_q      <= dgot_d;
      igot_q      <= igot_d;
      cyc_cnt_q   <= cyc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign halt      = in_halt;
  assign cyc_cnt   = cyc_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
//   Scoreboard bench for pipeline_ctrl. Each cycle a reference model
//   derives the expected strobes/counters from the applied inputs, pushes
//   them to a queue, and the entry is popped and compared once outputs
//   settle. Directed checks cover the scenario-specific expectations.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  logic        CLK, RST;
  logic        ihit, dhit, mem_ren_i, mem_wen_i, ex_memread, br_taken, wb_halt;
  regbits_t    ex_rd, id_rs, id_rt;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_clr, idex_clr, exmem_clr, memwb_clr;
  logic        dmem_ren, dmem_wen, halt;
  logic [31:0] cyc_cnt, stall_cnt;

  pipeline_ctrl #(.CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .mem_ren_i(mem_ren_i), .mem_wen_i(mem_wen_i),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
    .br_taken(br_taken), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_clr(ifid_clr), .idex_clr(idex_clr),
    .exmem_clr(exmem_clr), .memwb_clr(memwb_clr),
    .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .halt(halt),
    .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Strobe vector order:
  // {pc, ifid_en, idex_en, exmem_en, memwb_en, ifid_clr, idex_clr, exmem_clr, memwb_clr, dren, dwen, halt}
  typedef struct packed {
    logic [11:0] strb;
    logic [31:0] cyc;
    logic [31:0] stall;
  } exp_t;

  exp_t sb[$];

  pctrl_state_t m_state;
  logic         m_dgot, m_igot;
  logic [31:0]  m_cyc, m_stall;

  function automatic logic [11:0] act_strb();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
            ifid_clr, idex_clr, exmem_clr, memwb_clr, dmem_ren, dmem_wen, halt};
  endfunction

  function automatic logic lu_cond();
    return ex_memread && ex_rd != 5'd0 && (ex_rd == id_rs || ex_rd == id_rt);
  endfunction

  // Predict this cycle's outputs, queue them, let the DUT settle, compare.
  task automatic eval_cycle();
    exp_t e;
    exp_t got;
    logic stop, go;
    e = '0;
    if (RST) begin
      m_state = RUN; m_dgot = 1'b0; m_igot = 1'b0; m_cyc = '0; m_stall = '0;
    end else begin
      stop = wb_halt || (m_state == HALT);
      go   = (!(mem_ren_i || mem_wen_i) || dhit || m_dgot) && (ihit || m_igot) && !stop;
      if (stop || !go)      e.strb[11:3] = 9'b0_0000_0000;
      else if (br_taken)    e.strb[11:3] = 9'b1_1111_1110;
      else if (lu_cond())   e.strb[11:3] = 9'b0_0111_0100;
      else                  e.strb[11:3] = 9'b1_1111_0000;
      e.strb[2] = mem_ren_i && !m_dgot && !stop;
      e.strb[1] = mem_wen_i && !m_dgot && !stop;
      e.strb[0] = (m_state == HALT);
      e.cyc     = m_cyc;
      e.stall   = m_stall;
    end
    sb.push_back(e);
    #2;
    got = sb.pop_front();
    check("strobes",   {20'd0, act_strb()}, {20'd0, got.strb});
    check("cyc_cnt",   cyc_cnt,   got.cyc);
    check("stall_cnt", stall_cnt, got.stall);
  endtask

  // Advance the model with the inputs applied this cycle, then clock.
  task automatic next_edge();
    logic stop, go, bub;
    pctrl_state_t ns;
    if (!RST) begin
      stop = wb_halt || (m_state == HALT);
      go   = (!(mem_ren_i || mem_wen_i) || dhit || m_dgot) && (ihit || m_igot) && !stop;
      bub  = go && !br_taken && lu_cond();
      ns = m_state;
      if (m_state != HALT && wb_halt) ns = HALT;
      else if (m_state == RUN && (mem_ren_i || mem_wen_i) && !dhit && !m_dgot) ns = MWAIT;
      else if (m_state == MWAIT && dhit) ns = RUN;
      if (m_state != HALT) m_cyc = m_cyc + 1;
      if (!stop && (!go || bub)) m_stall = m_stall + 1;
      if (bub)       m_igot = m_igot | ihit;
      else if (go)   m_igot = 1'b0;
      else if (ihit) m_igot = 1'b1;
      if (go)        m_dgot = 1'b0;
      else if (dhit) m_dgot = 1'b1;
      m_state = ns;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic step();
    eval_cycle();
    next_edge();
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; mem_ren_i = 1'b0; mem_wen_i = 1'b0;
    ex_memread = 1'b0; ex_rd = 5'd0; id_rs = 5'd1; id_rt = 5'd2;
    br_taken = 1'b0; wb_halt = 1'b0;
  endtask

  logic [31:0] base;
  int          cnt;

  initial begin
    RST = 1'b1;
    idle();
    m_state = RUN; m_dgot = 1'b0; m_igot = 1'b0; m_cyc = '0; m_stall = '0;

    // Reset held for two cycles with ihit high.
    for (int i = 0; i < 2; i++) begin
      eval_cycle();
      check("rst_halt", {31'd0, halt}, 32'd0);
      check("rst_pc_en", {31'd0, pc_en}, 32'd0);
      check("rst_cyc", cyc_cnt, 32'd0);
      next_edge();
    end
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      eval_cycle();
      check("run_pc_en", {31'd0, pc_en}, 32'd1);
      check("run_all_en", {27'd0, ifid_en, idex_en, exmem_en, memwb_en}, 32'hF);
      next_edge();
    end
    check("run_stall", stall_cnt, 32'd0);

    // Load completing with dhit on the third cycle.
    base = stall_cnt; cnt = 0;
    mem_ren_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dhit = (i == 2);
      eval_cycle();
      if (dmem_ren) cnt++;
      if (i < 2) check("ld_frozen_en", {28'd0, ifid_en, idex_en, exmem_en, memwb_en}, 32'd0);
      else       check("ld_adv_en", {31'd0, memwb_en}, 32'd1);
      next_edge();
    end
    check("ld_dren_cycles", cnt, 32'd3);
    check("ld_stall", stall_cnt - base, 32'd2);
    idle(); step();

    // dhit arrives before ihit: request must not be re-issued.
    mem_ren_i = 1'b1; ihit = 1'b0; dhit = 1'b1;
    step();
    dhit = 1'b0;
    eval_cycle(); check("dg_dren_c2", {31'd0, dmem_ren}, 32'd0); next_edge();
    ihit = 1'b1;
    eval_cycle();
    check("dg_dren_c3", {31'd0, dmem_ren}, 32'd0);
    check("dg_adv_c3", {31'd0, pc_en}, 32'd1);
    next_edge();
    idle(); step();

    // Store stalled, fetch captured early via igot.
    mem_wen_i = 1'b1; dhit = 1'b0;
    step();
    ihit = 1'b0; dhit = 1'b1;
    eval_cycle(); check("ig_adv", {31'd0, pc_en}, 32'd1); next_edge();
    idle(); step();

    // Load-use hazard through rt, then through rs.
    base = stall_cnt;
    ex_memread = 1'b1; ex_rd = 5'd8; id_rt = 5'd8;
    eval_cycle();
    check("lu_pc_en", {31'd0, pc_en}, 32'd0);
    check("lu_ifid_en", {31'd0, ifid_en}, 32'd0);
    check("lu_idex_clr", {31'd0, idex_clr}, 32'd1);
    check("lu_exmem_en", {31'd0, exmem_en}, 32'd1);
    next_edge();
    idle();
    eval_cycle(); check("lu_one_cycle", {31'd0, pc_en}, 32'd1); next_edge();
    check("lu_stall", stall_cnt - base, 32'd1);
    ex_memread = 1'b1; ex_rd = 5'd9; id_rs = 5'd9; step();
    // $zero destination is not a hazard.
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; step();
    // Load-use bubble with ihit: fetch remembered for the next cycle.
    ex_memread = 1'b1; ex_rd = 5'd4; id_rs = 5'd4; step();
    idle(); ihit = 1'b0; step();
    idle();

    // Branch together with load-use: flush wins.
    br_taken = 1'b1; ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
    eval_cycle();
    check("br_clrs", {29'd0, ifid_clr, idex_clr, exmem_clr}, 32'd7);
    check("br_pc_en", {31'd0, pc_en}, 32'd1);
    check("br_memwb_clr", {31'd0, memwb_clr}, 32'd0);
    next_edge();
    idle(); step();

    // Reset in the middle of a memory wait.
    mem_ren_i = 1'b1; step(); step();
    RST = 1'b1;
    eval_cycle(); check("rst_mw_dren", {31'd0, dmem_ren}, 32'd0); next_edge();
    RST = 1'b0; idle();
    step(); step();

    // Randomised traffic (no halt).
    for (int i = 0; i < 300; i++) begin
      ihit       = ($urandom_range(0, 3) != 0);
      dhit       = ($urandom_range(0, 2) == 0);
      mem_ren_i  = ($urandom_range(0, 3) == 0);
      mem_wen_i  = !mem_ren_i && ($urandom_range(0, 4) == 0);
      ex_memread = ($urandom_range(0, 2) == 0);
      ex_rd      = regbits_t'($urandom_range(0, 2) * 4);
      id_rs      = regbits_t'($urandom_range(0, 2) * 4);
      id_rt      = regbits_t'($urandom_range(0, 2) * 4);
      br_taken   = ($urandom_range(0, 7) == 0);
      step();
    end
    idle(); step();

    // Halt with a concurrent store hit: halt wins, store suppressed.
    wb_halt = 1'b1; dhit = 1'b1; mem_wen_i = 1'b1;
    eval_cycle();
    check("hl_en", {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 32'd0);
    check("hl_dwen", {31'd0, dmem_wen}, 32'd0);
    next_edge();
    idle();
    base = cyc_cnt;
    for (int i = 0; i < 4; i++) begin
      eval_cycle(); check("hl_sticky", {31'd0, halt}, 32'd1); next_edge();
    end
    check("hl_cyc_frozen", cyc_cnt, base);
    RST = 1'b1;
    eval_cycle(); check("hl_rst_clears", {31'd0, halt}, 32'd0); next_edge();
    RST = 1'b0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
